pipe_sequencer: RTL and testbench

Stage-sequencing controller for the fetch/decode/execute/writeback pipeline. It sits beside the execute stage and drives the per-stage advance enables. It inserts bubbles on read-after-write hazards, because the pipeline has no forwarding. It also holds the pipeline for multi-cycle MUL, flushes the front end on taken branches, and drains and halts on HLT.

---
 rtl/fde_pkg.sv | 56 +++++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipe_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pipe_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
// rtl/fde_pkg.sv - shared opcodes, sequencer state type and opcode decode helpers
package fde_pkg;

    localparam logic [15:0] OP_ADD = 16'h1;
    localparam logic [15:0] OP_SUB = 16'h2;
    localparam logic [15:0] OP_LDI = 16'h3;
    localparam logic [15:0] OP_NOT = 16'h4;
    localparam logic [15:0] OP_MOV = 16'h5;
    localparam logic [15:0] OP_AND = 16'h6;
    localparam logic [15:0] OP_OR  = 16'h7;
    localparam logic [15:0] OP_XOR = 16'h8;
    localparam logic [15:0] OP_BR  = 16'h9;
    localparam logic [15:0] OP_BNE = 16'hA;
    localparam logic [15:0] OP_SHL = 16'hB;
    localparam logic [15:0] OP_SHR = 16'hC;
    localparam logic [15:0] OP_MUL = 16'hD;
    localparam logic [15:0] OP_HLT = 16'hE;
    localparam logic [15:0] OP_NOP = 16'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_MUL_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    // Anything outside the decoded set falls through to default and behaves as NOP.
    function automatic logic op_writes(input logic [15:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LDI, OP_NOT, OP_MOV, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MUL:                  return 1'b1;
            OP_BR, OP_BNE, OP_HLT, OP_NOP:           return 1'b0;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic op_reads_a(input logic [15:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BNE, OP_MUL,
            OP_SHL, OP_SHR:                          return 1'b1;
            OP_LDI, OP_NOT, OP_MOV, OP_BR, OP_HLT, OP_NOP: return 1'b0;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic op_reads_b(input logic [15:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BNE, OP_MUL,
            OP_NOT, OP_MOV:                          return 1'b1;
            OP_LDI, OP_SHL, OP_SHR, OP_BR, OP_HLT, OP_NOP: return 1'b0;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - read-after-write comparator between ID_EX sources and the EX tracker
module hazard_detect
    import fde_pkg::*;
(
    input  logic        id_valid,
    input  logic [15:0] id_opcode,
    input  logic [4:0]  id_src_a,
    input  logic [4:0]  id_src_b,
    input  logic        ex_valid,
    input  logic        ex_writes,
    input  logic [4:0]  ex_dest,
    output logic        hazard
);

    logic match_a;
    logic match_b;

    // Only sources the opcode actually reads can conflict; r0 is never a real destination.
    always_comb begin
        match_a = op_reads_a(id_opcode) && (id_src_a == ex_dest);
        match_b = op_reads_b(id_opcode) && (id_src_b == ex_dest);
        hazard  = id_valid && ex_valid && ex_writes && (ex_dest != 5'd0) && (match_a || match_b);
    end

endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - stage advance controller: RAW bubbles, MUL hold, branch flush, HLT drain
module pipe_sequencer
    import fde_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        id_valid,
    input  logic [15:0] id_opcode,
    input  logic [4:0]  id_src_a,
    input  logic [4:0]  id_src_b,
    input  logic [4:0]  id_dest,
    input  logic        ex_branch_taken,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        bubble,
    output logic        ex_en,
    output logic        wb_en,
    output logic        flush,
    output logic        halted,
    output logic        busy
);

    localparam bit          MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic [3:0]  MUL_LOAD  = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

    state_e      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_dest_q, ex_dest_d;
    logic        ex_writes_q, ex_writes_d;
    logic        ex_is_hlt_q, ex_is_hlt_d;
    logic        ex_is_mul_q, ex_is_mul_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;

    logic        hazard;
    logic        fetch_c, decode_c, bubble_c, ex_c, wb_c, flush_c, clear_trk;

    hazard_detect u_hazard (
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_src_a  (id_src_a),
        .id_src_b  (id_src_b),
        .ex_valid  (ex_valid_q),
        .ex_writes (ex_writes_q),
        .ex_dest   (ex_dest_q),
        .hazard    (hazard)
    );

    // Next state, enables and tracker update; branch beats HLT beats MUL beats hazard.
    always_comb begin
        state_d     = state_q;
        ex_valid_d  = ex_valid_q;
        ex_dest_d   = ex_dest_q;
        ex_writes_d = ex_writes_q;
        ex_is_hlt_d = ex_is_hlt_q;
        ex_is_mul_d = ex_is_mul_q;
        mul_cnt_d   = mul_cnt_q;
        fetch_c     = 1'b0;
        decode_c    = 1'b0;
        bubble_c    = 1'b0;
        ex_c        = 1'b0;
        wb_c        = 1'b0;
        flush_c     = 1'b0;
        clear_trk   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    fetch_c  = 1'b1;
                    ex_c     = 1'b1;
                    wb_c     = 1'b1;
                end else if (ex_valid_q && ex_is_hlt_q) begin
                    bubble_c = 1'b1;
                    ex_c     = 1'b1;
                    wb_c     = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (ex_valid_q && ex_is_mul_q && MUL_MULTI) begin
                    ex_c      = 1'b1;
                    mul_cnt_d = MUL_LOAD;
                    state_d   = ST_MUL_WAIT;
                end else if (hazard) begin
                    bubble_c = 1'b1;
                    ex_c     = 1'b1;
                    wb_c     = 1'b1;
                end else begin
                    fetch_c  = 1'b1;
                    decode_c = 1'b1;
                    ex_c     = 1'b1;
                    wb_c     = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                ex_c = 1'b1;
                if (mul_cnt_q == 4'd0) begin
                    wb_c      = 1'b1;
                    clear_trk = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                wb_c    = 1'b1;
                state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase

        if (decode_c || bubble_c) begin
            ex_valid_d  = id_valid && !bubble_c;
            ex_dest_d   = id_dest;
            ex_writes_d = op_writes(id_opcode);
            ex_is_hlt_d = (id_opcode == OP_HLT);
            ex_is_mul_d = (id_opcode == OP_MUL);
        end
        if (clear_trk) begin
            ex_valid_d  = 1'b0;
            ex_dest_d   = 5'd0;
            ex_writes_d = 1'b0;
            ex_is_hlt_d = 1'b0;
            ex_is_mul_d = 1'b0;
        end
    end

    // State, tracker and MUL counter registers; reset wins over start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= 5'd0;
            ex_writes_q <= 1'b0;
            ex_is_hlt_q <= 1'b0;
            ex_is_mul_q <= 1'b0;
            mul_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_writes_q <= ex_writes_d;
            ex_is_hlt_q <= ex_is_hlt_d;
            ex_is_mul_q <= ex_is_mul_d;
            mul_cnt_q   <= mul_cnt_d;
        end
    end

    // Enables are suppressed while reset is held so an interrupted MUL or DRAIN never writes back.
    always_comb begin
        fetch_en  = fetch_c  && !reset;
        decode_en = decode_c && !reset;
        bubble    = bubble_c && !reset;
        ex_en     = ex_c     && !reset;
        wb_en     = wb_c     && !reset;
        flush     = flush_c  && !reset;
        halted    = (state_q == ST_HALTED);
        busy      = (state_q == ST_RUN) || (state_q == ST_MUL_WAIT) || (state_q == ST_DRAIN);
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - scoreboard bench for pipe_sequencer with MUL_LATENCY 3 and 1
module tb_pipe_sequencer;

    localparam int M_IDLE = 0, M_RUN = 1, M_MUL = 2, M_DRAIN = 3, M_HALT = 4;

    typedef struct {
        bit          v;
        logic [15:0] op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  d;
    } instr_t;

    typedef struct {
        int          mode;
        bit          ev;
        logic [4:0]  ed;
        bit          ew;
        bit          eh;
        bit          em;
        int          mul_done;
    } mstate_t;

    // {fetch, decode, bubble, ex, wb, flush, halted, busy}
    typedef logic [7:0] exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        id_valid;
    logic [15:0] id_opcode;
    logic [4:0]  id_src_a;
    logic [4:0]  id_src_b;
    logic [4:0]  id_dest;
    logic        ex_branch_taken;

    logic fetch_en0, decode_en0, bubble0, ex_en0, wb_en0, flush0, halted0, busy0;
    logic fetch_en1, decode_en1, bubble1, ex_en1, wb_en1, flush1, halted1, busy1;
    exp_t act0, act1;

    assign act0 = {fetch_en0, decode_en0, bubble0, ex_en0, wb_en0, flush0, halted0, busy0};
    assign act1 = {fetch_en1, decode_en1, bubble1, ex_en1, wb_en1, flush1, halted1, busy1};

    pipe_sequencer #(.MUL_LATENCY(3)) dut0 (
        .clock(clock), .reset(reset), .start(start), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_dest(id_dest),
        .ex_branch_taken(ex_branch_taken),
        .fetch_en(fetch_en0), .decode_en(decode_en0), .bubble(bubble0), .ex_en(ex_en0),
        .wb_en(wb_en0), .flush(flush0), .halted(halted0), .busy(busy0)
    );

    pipe_sequencer #(.MUL_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_dest(id_dest),
        .ex_branch_taken(ex_branch_taken),
        .fetch_en(fetch_en1), .decode_en(decode_en1), .bubble(bubble1), .ex_en(ex_en1),
        .wb_en(wb_en1), .flush(flush1), .halted(halted1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t    q0[$];
    exp_t    q1[$];
    instr_t  prog[$];
    instr_t  cur;
    mstate_t m0, m1;
    bit      rand_mode;
    int      n_vec;
    int      n_miss;
    int      cyc;

    function automatic bit m_writes(input logic [15:0] op);
        return op inside {16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'hB, 16'hC, 16'hD};
    endfunction

    function automatic bit m_uses_a(input logic [15:0] op);
        return op inside {16'h1, 16'h2, 16'h6, 16'h7, 16'h8, 16'hA, 16'hD, 16'hB, 16'hC};
    endfunction

    function automatic bit m_uses_b(input logic [15:0] op);
        return op inside {16'h1, 16'h2, 16'h6, 16'h7, 16'h8, 16'hA, 16'hD, 16'h4, 16'h5};
    endfunction

    function automatic instr_t mk(input bit v, input logic [15:0] op, input logic [4:0] d,
                                  input logic [4:0] a, input logic [4:0] b);
        instr_t i;
        i.v = v; i.op = op; i.d = d; i.a = a; i.b = b;
        return i;
    endfunction

    // One cycle of the reference pipeline: expected outputs now, model state after the edge.
    function automatic exp_t model_step(input int lat, inout mstate_t s, input bit rst,
                                        input bit st, input bit br, input instr_t in);
        bit fe = 0, de = 0, bu = 0, ee = 0, we = 0, fl = 0;
        bit ha = (s.mode == M_HALT);
        bit bz = (s.mode == M_RUN) || (s.mode == M_MUL) || (s.mode == M_DRAIN);
        bit haz;
        haz = in.v && s.ev && s.ew && (s.ed != 5'd0) &&
              ((m_uses_a(in.op) && in.a == s.ed) || (m_uses_b(in.op) && in.b == s.ed));
        case (s.mode)
            M_IDLE, M_HALT: if (st) s.mode = M_RUN;
            M_RUN: begin
                if (br) begin
                    fl = 1; bu = 1; fe = 1; ee = 1; we = 1; s.ev = 0;
                end else if (s.ev && s.eh) begin
                    bu = 1; ee = 1; we = 1; s.ev = 0; s.mode = M_DRAIN;
                end else if (s.ev && s.em && lat > 1) begin
                    ee = 1; s.mul_done = 1; s.mode = M_MUL;
                end else if (haz) begin
                    bu = 1; ee = 1; we = 1; s.ev = 0;
                end else begin
                    fe = 1; de = 1; ee = 1; we = 1;
                    s.ev = in.v; s.ed = in.d; s.ew = m_writes(in.op);
                    s.eh = (in.op == 16'hE); s.em = (in.op == 16'hD);
                end
            end
            M_MUL: begin
                ee = 1;
                s.mul_done++;
                if (s.mul_done == lat) begin
                    we = 1; s.ev = 0; s.mode = M_RUN;
                end
            end
            M_DRAIN: begin
                we = 1; s.mode = M_HALT;
            end
            default: s.mode = M_IDLE;
        endcase
        if (rst) begin
            fe = 0; de = 0; bu = 0; ee = 0; we = 0; fl = 0;
            s.mode = M_IDLE; s.ev = 0; s.mul_done = 0;
        end
        return {fe, de, bu, ee, we, fl, ha, bz};
    endfunction

    function automatic instr_t next_instr();
        instr_t i;
        int pick;
        if (prog.size() > 0) return prog.pop_front();
        if (!rand_mode) return mk(0, 16'hF, 0, 0, 0);
        pick = $urandom_range(0, 40);
        i.v = ($urandom_range(0, 7) != 0);
        if (pick == 0)      i.op = 16'hE;
        else if (pick == 1) i.op = 16'h0;
        else if (pick == 2) i.op = 16'h1234;
        else if (pick == 3) i.op = 16'hF;
        else                i.op = 16'($urandom_range(1, 13));
        i.a = 5'($urandom_range(0, 3));
        i.b = 5'($urandom_range(0, 3));
        i.d = 5'($urandom_range(0, 3));
        return i;
    endfunction

    task automatic cycle(input bit rst, input bit st, input bit br);
        exp_t e0, e1;
        @(posedge clock);
        #1;
        reset           = rst;
        start           = st;
        ex_branch_taken = br;
        id_valid        = cur.v;
        id_opcode       = cur.op;
        id_src_a        = cur.a;
        id_src_b        = cur.b;
        id_dest         = cur.d;
        e0 = model_step(3, m0, rst, st, br, cur);
        e1 = model_step(1, m1, rst, st, br, cur);
        q0.push_back(e0);
        q1.push_back(e1);
        if (e0[6] || e0[2]) cur = next_instr();
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d actual %b required %b (fe de bu ex wb fl ha bz)",
                     name, cyc, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUTs present against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            cyc++;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                check("lat3_outputs", act0, x);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                check("lat1_outputs", act1, x);
            end
        end
    end

    initial begin
        bit rst, st, br;
        n_vec = 0; n_miss = 0; cyc = 0; rand_mode = 0;
        m0 = '{mode: M_IDLE, ev: 0, ed: 0, ew: 0, eh: 0, em: 0, mul_done: 0};
        m1 = m0;
        reset = 1; start = 0; ex_branch_taken = 0;
        id_valid = 0; id_opcode = 16'hF; id_src_a = 0; id_src_b = 0; id_dest = 0;

        // Independent ops, RAW stall, r0 writer, MUL hold, then a follower.
        cur = mk(1, 16'h1, 1, 2, 3);
        prog.push_back(mk(1, 16'h2, 4, 5, 6));
        prog.push_back(mk(1, 16'h1, 3, 1, 2));
        prog.push_back(mk(1, 16'h8, 4, 3, 5));
        prog.push_back(mk(1, 16'h1, 0, 1, 2));
        prog.push_back(mk(1, 16'h7, 5, 0, 0));
        prog.push_back(mk(1, 16'hD, 6, 1, 2));
        prog.push_back(mk(1, 16'h2, 7, 6, 1));
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0);

        // Taken branch while a RAW hazard is pending.
        cur = mk(1, 16'h1, 3, 1, 2);
        prog.push_back(mk(1, 16'h8, 4, 3, 5));
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);

        // HLT drains, halts, and start resumes.
        cur = mk(1, 16'hE, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Random traffic with branches, restarts, stray starts and rare resets.
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (m0.mode == M_IDLE || m0.mode == M_HALT) st = ($urandom_range(0, 3) == 0);
            else                                        st = ($urandom_range(0, 15) == 0);
            br  = ($urandom_range(0, 9) == 0);
            cycle(rst, st, br);
        end

        // Reset landing in the middle of a MUL hold.
        rand_mode = 0;
        prog.delete();
        cur = mk(1, 16'hD, 1, 2, 3);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 10 && m0.mode != M_MUL; i++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
